// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding slot per functional unit, one registered broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module cdb_arbiter #(
   parameter int                   N_REQ     = 4,
   parameter int                   UNIT_SIZE = 8,
   parameter int                   WORD_SIZE = 32,
   parameter logic [UNIT_SIZE-1:0] IDLE_TAG  = 8'b01111111
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*UNIT_SIZE-1:0] req_tag,
   input  logic [N_REQ*WORD_SIZE-1:0] req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       cdb_valid,
   output logic [UNIT_SIZE-1:0]       cdb_tag,
   output logic [WORD_SIZE-1:0]       cdb_data,
   output logic [3:0]                 pending,
   output logic                       err_idle_tag
);

   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0]     slot_full;
   logic [UNIT_SIZE-1:0] slot_tag  [N_REQ];
   logic [WORD_SIZE-1:0] slot_data [N_REQ];

   logic [N_REQ-1:0]     accept;
   logic [3:0]           accept_cnt;
   logic                 idle_hit;
   logic                 gnt_any;
   logic [IW-1:0]        gnt_idx;
   logic [N_REQ-1:0]     gnt_vec;

   assign req_ready = ~slot_full;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      accept     = '0;
      accept_cnt = '0;
      idle_hit   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_valid[i] && !slot_full[i]) begin
            if (req_tag[i*UNIT_SIZE +: UNIT_SIZE] == IDLE_TAG) idle_hit  = 1'b1;
            else                                               accept[i] = 1'b1;
         end
         accept_cnt = accept_cnt + 4'(accept[i]);
      end
   end

`ifdef CDB_RR_EN
   logic [IW-1:0] rr_ptr;
   logic [IW:0]   rr_idx;

   // Search starts at the pointer and wraps; the first full slot met wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      rr_idx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         rr_idx = {1'b0, rr_ptr} + (IW+1)'(k);
         if (rr_idx >= (IW+1)'(N_REQ)) rr_idx = rr_idx - (IW+1)'(N_REQ);
         if (!gnt_any && slot_full[rr_idx[IW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_idx[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       rr_ptr <= '0;
      else if (gnt_any) rr_ptr <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
   end
`else
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!gnt_any && slot_full[k]) begin
            gnt_any = 1'b1;
            gnt_idx = IW'(k);
         end
      end
   end
`endif

   always_comb begin
      gnt_vec = '0;
      if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_full    <= '0;
         pending      <= '0;
         err_idle_tag <= 1'b0;
         cdb_valid    <= 1'b0;
         cdb_tag      <= IDLE_TAG;
         cdb_data     <= '0;
      end else begin
         // A granted slot is full, so it cannot also accept at this edge.
         slot_full <= (slot_full & ~gnt_vec) | accept;
         pending   <= pending + accept_cnt - 4'(gnt_any);
         if (idle_hit) err_idle_tag <= 1'b1;
         if (gnt_any) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= slot_tag[gnt_idx];
            cdb_data  <= slot_data[gnt_idx];
         end else begin
            cdb_valid <= 1'b0;
            cdb_tag   <= IDLE_TAG;
            cdb_data  <= '0;
         end
      end
   end

   // NOTE: slot payload is not reset; slot_full alone decides whether it means anything.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (accept[i]) begin
            slot_tag[i]  <= req_tag[i*UNIT_SIZE +: UNIT_SIZE];
            slot_data[i] <= req_data[i*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter: behavioural slot model feeds a broadcast scoreboard.
// Honours CDB_RR_EN the same way as the design.
module tb_cdb_arbiter;

   localparam int         N    = 4;
   localparam int         TW   = 8;
   localparam int         DW   = 32;
   localparam logic [7:0] IDLE = 8'h7F;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } bcast_t;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*TW-1:0] req_tag;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic [3:0]      pending;
   logic            err_idle_tag;

   cdb_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_tag      (req_tag),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data),
      .pending      (pending),
      .err_idle_tag (err_idle_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: slot contents, sticky error, next round-robin start unit.
   bit            m_full [N];
   logic [TW-1:0] m_tag  [N];
   logic [DW-1:0] m_data [N];
   bit            m_err;
   int            m_start;
   bcast_t        exp_q [$];

   int n_vec;
   int n_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < N; u++) m_full[u] = 0;
      m_err   = 0;
      m_start = 0;
      exp_q.delete();
   endtask

   // One clock edge of the abstract behaviour: pick a winner, broadcast it, then capture offers.
   task automatic model_step();
      bit was_full [N];
      int win;
      for (int u = 0; u < N; u++) was_full[u] = m_full[u];
      win = -1;
`ifdef CDB_RR_EN
      for (int k = 0; k < N; k++) begin
         int u;
         u = (m_start + k) % N;
         if (win < 0 && m_full[u]) win = u;
      end
      if (win >= 0) m_start = (win + 1) % N;
`else
      for (int u = N - 1; u >= 0; u--) if (m_full[u]) win = u;
`endif
      if (win >= 0) begin
         exp_q.push_back('{tag: m_tag[win], data: m_data[win]});
         m_full[win] = 0;
      end
      for (int u = 0; u < N; u++) begin
         if (req_valid[u] && !was_full[u]) begin
            if (req_tag[u*TW +: TW] == IDLE) m_err = 1;
            else begin
               m_full[u] = 1;
               m_tag[u]  = req_tag[u*TW +: TW];
               m_data[u] = req_data[u*DW +: DW];
            end
         end
      end
   endtask

   task automatic check_state();
      logic [N-1:0] exp_ready;
      int           cnt;
      cnt = 0;
      for (int u = 0; u < N; u++) begin
         exp_ready[u] = !m_full[u];
         cnt += m_full[u] ? 1 : 0;
      end
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("pending", 64'(pending), 64'(cnt));
      check("err_idle_tag", 64'(err_idle_tag), 64'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      check_state();
   endtask

   task automatic post(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d);
      req_valid[u]       = 1'b1;
      req_tag[u*TW +: TW] = t;
      req_data[u*DW +: DW] = d;
   endtask

   task automatic idle_bus();
      req_valid = '0;
   endtask

   // Monitor: every DUT broadcast must match the next expected one, in lock-step.
   initial begin
      bcast_t e;
      forever begin
         @(negedge clk);
         if (cdb_valid) begin
            if (exp_q.size() == 0) check("cdb_spurious", 64'(cdb_valid), 64'(0));
            else begin
               e = exp_q.pop_front();
               check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
               check("cdb_data", 64'(cdb_data), 64'(e.data));
            end
         end else begin
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("cdb_missing", 64'(cdb_valid), 64'(1));
            end
            check("cdb_idle", {24'h0, cdb_tag, cdb_data}, {24'h0, IDLE, 32'h0});
         end
      end
   end

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_tag   = '0;
      req_data  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_state();

      // Single request, then drain.
      post(1, 8'h03, 32'h0000_00AA);
      tick();
      idle_bus();
      repeat (3) tick();

      // Four-way contention.
      for (int u = 0; u < N; u++) post(u, 8'h10 + 8'(u), 32'h1000 + 32'(u));
      tick();
      idle_bus();
      repeat (6) tick();

      // IDLE_TAG request is dropped and flagged.
      post(3, IDLE, 32'hDEAD_BEEF);
      tick();
      idle_bus();
      repeat (2) tick();

      // Back-to-back re-posting from unit 0 alone.
      for (int c = 0; c < 10; c++) begin
         idle_bus();
         if (!m_full[0]) post(0, 8'h20 + 8'(c), 32'hB000 + 32'(c));
         tick();
      end
      idle_bus();
      repeat (3) tick();

      // Fairness: unit 0 keeps re-posting, unit 2 posts once.
      for (int c = 0; c < 10; c++) begin
         idle_bus();
         if (!m_full[0]) post(0, 8'h30 + 8'(c), 32'hC000 + 32'(c));
         if (c == 1) post(2, 8'h42, 32'h0000_4242);
         tick();
      end
      idle_bus();
      repeat (4) tick();

      // Asynchronous reset mid-cycle with slots 0 and 2 full and a broadcast in flight.
      post(1, 8'h51, 32'h5151);
      tick();
      idle_bus();
      post(0, 8'h50, 32'h5050);
      post(2, 8'h52, 32'h5252);
      tick();
      idle_bus();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
      check("rst_cdb_tag", 64'(cdb_tag), 64'(IDLE));
      check("rst_req_ready", 64'(req_ready), 64'(4'b1111));
      check("rst_pending", 64'(pending), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick();

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < N; u++) begin
            req_valid[u] = ($urandom_range(0, 1) == 1);
            req_tag[u*TW +: TW] = ($urandom_range(0, 15) == 0) ? IDLE : 8'($urandom);
            req_data[u*DW +: DW] = $urandom;
         end
         tick();
      end
      idle_bus();
      repeat (N + 2) tick();
      check("drain_empty", 64'(exp_q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the common data bus (CDB) among N_REQ functional units finishing in the same cycle.
- Each unit posts a (unit tag, result) pair into a private one-entry holding slot.
- The arbiter grants one slot per cycle and drives the registered broadcast (valid/tag/data) that feeds the register rename/status table's check/write/inrf inputs and the reservation stations.
- Sits between functional-unit outputs and the rename table.

Parameters:
- N_REQ, 4, number of requesting functional units (2..8).
- UNIT_SIZE, 8, width of a unit tag.
- WORD_SIZE, 32, width of a result word.
- IDLE_TAG, 8'b01111111, reserved tag meaning "no unit / value present"; never broadcast.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-unit result offer.
- req_tag  input  N_REQ*UNIT_SIZE  per-unit producing tag; unit i occupies bits [i*UNIT_SIZE +: UNIT_SIZE].
- req_data  input  N_REQ*WORD_SIZE  per-unit result; unit i occupies [i*WORD_SIZE +: WORD_SIZE].
- req_ready  output  N_REQ  slot i empty; a transfer occurs at the edge where req_valid[i] && req_ready[i].
- cdb_valid  output  1  broadcast strobe (to rename table check).
- cdb_tag  output  UNIT_SIZE  broadcast tag (to rename table write).
- cdb_data  output  WORD_SIZE  broadcast value (to rename table inrf).
- pending  output  4  count of full slots, 0..N_REQ.
- err_idle_tag  output  1  sticky; a request carried IDLE_TAG.

Behaviour:
- Reset (async assert, any time, including mid-operation):
  - all slots emptied; pending data discarded.
  - req_ready = all 1s; pending = 0.
  - RR pointer = 0; err_idle_tag = 0.
  - cdb_valid = 0; cdb_tag = IDLE_TAG; cdb_data = 0.
- req_ready[i] = !slot_full[i], purely from registered state; no combinational path from req_valid.
- A slot granted at edge t is empty in the cycle after t. It can accept new data at edge t+1, never at edge t.
- Capture: on a transfer, the slot stores the tag and data.
  - If the tag == IDLE_TAG, the slot stays empty, the request is dropped, and err_idle_tag is set until reset.
- Arbitration happens every cycle over full slots only:
  - the winner is cleared at the edge.
  - at that same edge, cdb_valid <= 1, cdb_tag <= slot tag, cdb_data <= slot data.
- If no slot is full: cdb_valid <= 0, cdb_tag <= IDLE_TAG, cdb_data <= 0. A broadcast is exactly one cycle wide.
- Latency: request accepted at edge t, with no contention → cdb_valid high during the cycle after edge t+1.
- Throughput: one broadcast per cycle. Under contention, the losers hold their slots and stay ready=0.
- pending is updated each edge: +transfers accepted (non-IDLE) − 1 if granted.
  - A simultaneous accept and grant is net-counted.
- Tags of distinct slots are not checked for duplicates. Both are broadcast in arbitration order.

Optional Feature:
- Macro: CDB_RR_EN.
- Defined: round-robin arbitration.
  - The search starts at the RR pointer and wraps modulo N_REQ.
  - On a grant to i, pointer <= (i+1) mod N_REQ. With no grant, the pointer holds.
  - Any full slot is granted within N_REQ cycles.
- Undefined: fixed priority, lowest index wins. The pointer register is not instantiated. Unit 0 can starve others.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with slots 0,2 full → immediately cdb_valid=0, cdb_tag=8'h7F, req_ready=4'b1111, pending=0; no later broadcast of the discarded data.
- Single request: unit 1 posts tag 8'h03, data 32'h0000_00AA, accepted at edge t → cdb_valid=1, tag 8'h03, data 32'h0000_00AA in the cycle after t+1 only; req_ready[1]=0 for one cycle.
- Contention (CDB_RR_EN): units 0..3 post tags 8'h10..8'h13 in the same cycle → broadcasts 8'h10, 8'h11, 8'h12, 8'h13 on consecutive cycles; pointer ends at 0; pending counts 4,3,2,1,0.
- Fairness (CDB_RR_EN): unit 0 re-posts every cycle it is ready, unit 2 posts once → unit 2 is broadcast within 2 cycles. Without the macro, the same stimulus keeps granting unit 0 while it is full and unit 2 waits.
- IDLE_TAG: unit 3 posts tag 8'h7F, data 32'hDEAD_BEEF → no broadcast, err_idle_tag=1 sticky, req_ready[3] stays 1, pending unchanged.
- Back-to-back: unit 0 re-posts at the first edge ready=1 after its grant → broadcasts of unit 0 are spaced exactly 2 cycles apart with no other requesters.
